// File: rtl/alu_md_seq_if.sv
// alu_md_seq_if: issue/result bus between the control unit and the multiply/divide sequencer
interface alu_md_seq_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] aux;
    logic             v;
    logic             dz;
    logic             z;
    logic             s;
    modport master (output start, op, src, dst, input busy, done, result, aux, v, dz, z, s);
    modport slave  (input start, op, src, dst, output busy, done, result, aux, v, dz, z, s);
endinterface

// File: rtl/alu_md_seq.sv
// alu_md_seq: iterative shift-add multiplier / restoring divider; divider built only with ALU_MD_DIV_EN
module alu_md_seq #(parameter int WIDTH = 16) (
    input logic         clk,
    input logic         rst_n,
    alu_md_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               op_r;
    logic [WIDTH-1:0]   m_r;
    logic [2*WIDTH-1:0] p, p_nx, mul_nx, div_nx;
    logic [WIDTH:0]     sum, sh, diff;
    logic               go, fast, last;
    assign go   = bus.start && state != RUN;
    assign last = cnt == CW'(WIDTH - 1);
`ifdef ALU_MD_DIV_EN
    assign fast = bus.op && bus.src == '0;
`else
    assign fast = bus.op;
`endif
    // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? m_r : '0};
        mul_nx = {sum, p[WIDTH-1:1]};
        sh     = p[2*WIDTH-1:WIDTH-1];
        diff   = sh - {1'b0, m_r};
        div_nx = diff[WIDTH] ? {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
`ifdef ALU_MD_DIV_EN
        p_nx   = op_r ? div_nx : mul_nx;
`else
        p_nx   = mul_nx;
`endif
    end
    always_comb begin
        state_nx = IDLE;
        if (go)
            state_nx = fast ? FIN : RUN;
        else if (state == RUN)
            state_nx = last ? FIN : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_r       <= 1'b0;
            m_r        <= '0;
            p          <= '0;
            bus.result <= '0;
            bus.aux    <= '0;
            bus.v      <= 1'b0;
            bus.dz     <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                op_r <= bus.op;
                m_r  <= bus.op ? bus.src : bus.dst;
                p    <= {{WIDTH{1'b0}}, bus.op ? bus.dst : bus.src};
                cnt  <= '0;
                if (fast) begin
`ifdef ALU_MD_DIV_EN
                    bus.result <= '1;
                    bus.aux    <= bus.dst;
`else
                    bus.result <= '0;
                    bus.aux    <= '0;
`endif
                    bus.v  <= 1'b0;
                    bus.dz <= 1'b1;
                end
            end else if (state == RUN) begin
                p   <= p_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    bus.result <= p_nx[WIDTH-1:0];
                    bus.aux    <= p_nx[2*WIDTH-1:WIDTH];
                    bus.v      <= !op_r && |p_nx[2*WIDTH-1:WIDTH];
                    bus.dz     <= 1'b0;
                end
            end
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == FIN;
    assign bus.z    = ~|bus.result;
    assign bus.s    = bus.result[WIDTH-1];
endmodule

// File: tb/tb_alu_md_seq.sv
// tb_alu_md_seq: directed test of alu_md_seq against a cycle-level arithmetic model
module tb_alu_md_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;
    alu_md_seq_if #(.WIDTH(16)) bus();
    alu_md_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an accepted op finishes 17 edges later (1 for the immediate cases)
    logic        m_busy, m_done, m_v, m_dz, p_v;
    logic [15:0] m_res, m_aux, p_res, p_aux;
    int          left;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_res <= 0; m_aux <= 0; m_v <= 0; m_dz <= 0; left <= 0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                left <= left - 1;
                if (left == 1) begin
                    m_busy <= 0; m_done <= 1; m_res <= p_res; m_aux <= p_aux; m_v <= p_v; m_dz <= 0;
                end
            end else if (bus.start) begin
                if (!bus.op) begin
                    p_res  <= 16'(32'(bus.dst) * 32'(bus.src));
                    p_aux  <= 16'((32'(bus.dst) * 32'(bus.src)) >> 16);
                    p_v    <= ((32'(bus.dst) * 32'(bus.src)) >> 16) != 0;
                    m_busy <= 1; left <= 16;
                end else begin
`ifdef ALU_MD_DIV_EN
                    if (bus.src == 0) begin
                        m_done <= 1; m_res <= 16'hFFFF; m_aux <= bus.dst; m_v <= 0; m_dz <= 1;
                    end else begin
                        p_res <= bus.dst / bus.src; p_aux <= bus.dst % bus.src; p_v <= 0;
                        m_busy <= 1; left <= 16;
                    end
`else
                    m_done <= 1; m_res <= 0; m_aux <= 0; m_v <= 0; m_dz <= 1;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            check("result", bus.result, m_res);
            check("aux", bus.aux, m_aux);
            check("v", bus.v, m_v);
            check("dz", bus.dz, m_dz);
            check("z", bus.z, m_res == 0);
            check("s", bus.s, m_res[15]);
            check("busy_done_excl", bus.busy & bus.done, 0);
        end
    end

    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b);
        bus.start = 1; bus.op = o; bus.src = a; bus.dst = b;
    endtask

    task automatic wait_done(input int lat, input string nm, input int poke);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.start = (n == poke);
            if (n == poke) begin bus.op = 0; bus.src = 5; bus.dst = 5; end
        end while (!bus.done && n < 40);
        bus.start = 0;
        check({nm, " latency"}, n, lat);
    endtask

    initial begin
        int nd;
        bus.start = 0; bus.op = 0; bus.src = 0; bus.dst = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst result", bus.result, 0);
        check("rst aux", bus.aux, 0);
        check("rst z", bus.z, 1);
        check("rst v", bus.v, 0);
        check("rst dz", bus.dz, 0);
        check("rst s", bus.s, 0);
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);

        issue(0, 16'h0010, 16'h1234);
        wait_done(17, "mul1234", 0);
        check("mul1234 result", bus.result, 16'h2340);
        check("mul1234 aux", bus.aux, 16'h0001);
        check("mul1234 v", bus.v, 1);

        issue(0, 16'h0003, 16'h5555);
        @(negedge clk);
        bus.start = 0;
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst result", bus.result, 0);
        check("midrst z", bus.z, 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        issue(0, 16'd4, 16'd3);
        wait_done(17, "mul3x4", 0);
        check("mul3x4 result", bus.result, 16'd12);
        check("mul3x4 v", bus.v, 0);

        @(negedge clk);
        issue(1, 16'd7, 16'd1000);
`ifdef ALU_MD_DIV_EN
        wait_done(17, "div1000", 0);
        check("div1000 result", bus.result, 16'd142);
        check("div1000 aux", bus.aux, 16'd6);
        check("div1000 dz", bus.dz, 0);
        check("div1000 z", bus.z, 0);
`else
        wait_done(1, "div1000", 0);
        check("div1000 result", bus.result, 0);
        check("div1000 dz", bus.dz, 1);
`endif
        check("div1000 v", bus.v, 0);

        @(negedge clk);
        issue(1, 16'd0, 16'h00AB);
        wait_done(1, "div0", 0);
`ifdef ALU_MD_DIV_EN
        check("div0 result", bus.result, 16'hFFFF);
        check("div0 aux", bus.aux, 16'h00AB);
        check("div0 s", bus.s, 1);
`else
        check("div0 result", bus.result, 0);
        check("div0 z", bus.z, 1);
`endif
        check("div0 dz", bus.dz, 1);

        @(negedge clk);
        issue(0, 16'd200, 16'd100);
        wait_done(17, "ignore", 3);
        check("ignore result", bus.result, 16'h4E20);
        check("ignore aux", bus.aux, 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        check("ignore extra done", nd, 0);

        issue(0, 16'd9, 16'd7);
        wait_done(17, "b2b first", 0);
        check("b2b first result", bus.result, 16'd63);
        issue(0, 16'hFFFF, 16'hFFFF);
        wait_done(17, "b2b second", 0);
        check("b2b result", bus.result, 16'h0001);
        check("b2b aux", bus.aux, 16'hFFFE);
        check("b2b v", bus.v, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
